// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver: internal baud divider, parity, stop-bit and overrun checks
// Optional break detection is compiled in when UART_RX_BREAK_DETECT_EN is defined.
module uart_rx_param #(
  parameter int CLK_HZ    = 48000000,
  parameter int BAUD      = 38400,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int BIT_DIV = CLK_HZ / BAUD;
  localparam int HALF    = BIT_DIV / 2;
  localparam int CW      = $clog2(BIT_DIV + 1);
  localparam int IW      = $clog2(DATA_BITS);

  if (BIT_DIV < 4) begin : g_chk_div
    $error("uart_rx_param: BIT_DIV must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_par
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                 state, state_next;
  logic                   rx_s1, rx_s2, rx_d;
  logic                   fall;
  logic [CW-1:0]          cnt;
  logic                   tick;
  logic                   cnt_load, cnt_half;
  logic                   frame_done, done_q;
  logic [IW-1:0]          idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   pbit;
  logic                   stop_idx;
  logic                   stop_last;
  logic                   stop_err;
  logic                   perr_calc;
  logic                   brk_cond;

  // rx_d is a third stage used only for edge detection on the synchronised line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign fall      = rx_d & ~rx_s2;
  assign tick      = (cnt == '0);
  assign stop_last = (stop_idx == 1'(STOP_BITS - 1));
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_half   = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) begin
          state_next = S_START;
          cnt_load   = 1'b1;
          cnt_half   = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if (rx_s2) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_DATA;
            cnt_load   = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_load = 1'b1;
          if (idx == IW'(DATA_BITS - 1))
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_load   = 1'b1;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_last) begin
            if (brk_cond) begin
              state_next = S_BREAK;
            end else begin
              state_next = S_IDLE;
              frame_done = 1'b1;
            end
          end else begin
            cnt_load = 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (rx_s2) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (cnt_load)
      cnt <= cnt_half ? CW'(HALF - 1) : CW'(BIT_DIV - 1);
    else if (cnt != '0)
      cnt <= cnt - CW'(1);
  end

  // Payload shifts in from the top so the first (LSB) bit ends at bit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      shift    <= '0;
      pbit     <= 1'b0;
      stop_idx <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      if (state == S_START && tick && !rx_s2) begin
        idx      <= '0;
        pbit     <= 1'b0;
        stop_idx <= 1'b0;
        stop_err <= 1'b0;
      end
      if (state == S_DATA && tick) begin
        shift <= {rx_s2, shift[DATA_BITS-1:1]};
        idx   <= idx + IW'(1);
      end
      if (state == S_PARITY && tick)
        pbit <= rx_s2;
      if (state == S_STOP && tick) begin
        stop_idx <= stop_idx + 1'b1;
        if (!rx_s2) stop_err <= 1'b1;
      end
    end
  end

  assign perr_calc = (PARITY != 0) && (((^shift) ^ pbit) != (PARITY == 2));

  // Payload registers are stable for at least half a bit after done, so they are read directly here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q      <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      done_q <= frame_done;
      if (data_valid && data_ready) begin
        data_valid  <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (done_q) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift;
          parity_err <= perr_calc;
          frame_err  <= stop_err;
          data_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic stop0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stop0 <= 1'b1;
    else if (state == S_STOP && tick && stop_idx == 1'b0)
      stop0 <= rx_s2;
  end

  assign brk_cond = (shift == '0) && !pbit && !((stop_idx == 1'b0) ? rx_s2 : stop0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) break_det <= 1'b0;
    else     break_det <= (state == S_STOP) && tick && stop_last && brk_cond;
  end
`else
  assign brk_cond  = 1'b0;
  assign break_det = 1'b0;
`endif

endmodule
